hs_therm_counter: RTL
=====================

// Module: hs_therm_counter
// PURPOSE
//  Clocked, parametrised thermometer counter driven by 4-phase req/ack handshakes from
//  asynchronous control stages. Counts up/down between 0 and DEPTH, flags terminal count,
//  and either wraps or saturates. It is the synchronous flow-control counter for loop and
//  burst bookkeeping in the pipeline.
// PARAMETERS
//  DEPTH        10  terminal count; value range 0..DEPTH (DEPTH >= 2)
//  MODE          0  0 = WRAP (DEPTH+1 -> 0, 0-1 -> DEPTH), 1 = SATURATE (hold at bounds)
//  SYNC_STAGES   2  synchroniser flops on incReq/decReq (>= 2)
//  CW           $clog2(DEPTH+1)  binary count width (derived, localparam)
// PORTS
//  clk       in   1      single clock; all state on posedge
//  rstN      in   1      asynchronous, active-low reset
//  incReq    in   1      4-phase increment request (async source)
//  incAck    out  1      4-phase increment acknowledge
//  decReq    in   1      4-phase decrement request (async source)
//  decAck    out  1      4-phase decrement acknowledge
//  clr       in   1      synchronous clear, clk-domain level, highest priority
//  therm     out  DEPTH  thermometer value: bits [k-1:0] set for count k
//  count     out  CW     binary value of therm
//  fin       out  1      level, high while count == DEPTH
//  wrapPulse out  1      1-cycle pulse on wrap (either direction), WRAP mode only
//  errPulse  out  1      1-cycle pulse on inc at DEPTH / dec at 0, SATURATE mode only
// BEHAVIOUR
//  Reset (rstN low, async): therm=0, count=0, fin=0, incAck=0, decAck=0, pulses=0,
//   synchronisers cleared, both channel FSMs in WAIT_LOW.
//  Channel FSM (per req): WAIT_LOW -(syncReq==0)-> IDLE -(syncReq==1)-> ACK -(syncReq==0)-> WAIT_LOW.
//   Entry into ACK is the single "accept" cycle; ack registered high from that edge on;
//   ack drops on the edge syncReq is seen low. Exactly one count event per req pulse.
//   Starting in WAIT_LOW means a req still high across reset is never counted.
//  Latency: req rise -> ack rise = SYNC_STAGES+1 clk; req fall -> ack fall = SYNC_STAGES+1 clk.
//  Update (same edge as accept): priority clr > (inc&dec) > inc > dec.
//   clr: count=0; any accept in that cycle is still acked but discarded.
//   inc&dec accepted same cycle: net zero, both acked, no pulses.
//   inc below DEPTH: therm={therm[DEPTH-2:0],1}. dec above 0: therm={0,therm[DEPTH-1:1]}.
//   inc at DEPTH: WRAP -> 0 + wrapPulse; SATURATE -> hold + errPulse.
//   dec at 0: WRAP -> DEPTH + wrapPulse; SATURATE -> hold + errPulse.
//  count, fin registered from the same next-state as therm (no skew between them).
//  therm is always a valid thermometer code; illegal codes unreachable, assert in sim.
// STRUCTURE
//  Package hs_counter_pkg: MODE_WRAP/MODE_SATURATE constants, channel state enum
//   {WAIT_LOW, IDLE, ACK}, therm2bin function.
//  Sub-module hs_req_chan: synchroniser + channel FSM, outputs ack and 1-cycle accept;
//   instantiated for inc and dec. Top holds therm register, priority logic, flags.
// TESTING
//  DEPTH=4, WRAP: 4 inc handshakes -> count 1,2,3,4, fin=1 after 4th; 5th -> count 0, wrapPulse x1.
//  DEPTH=4, SATURATE: 6 incs -> count holds 4, errPulse on 5th and 6th, incAck completes each.
//  dec at 0: WRAP -> count 4 + wrapPulse; SATURATE -> count 0 + errPulse.
//  inc and dec raised same cycle at count 2 -> both acks rise same edge, count stays 2.
//  clr held during inc accept at count 3 -> count 0, incAck still rises/falls normally.
//  rstN low mid-handshake with incReq high -> ack 0, count 0; no count until incReq low then high.

Source files
------------

// File: rtl/hs_counter_pkg.sv
// Shared constants, channel state encoding and thermometer-to-binary helper
// for the handshake-driven thermometer counter.
package hs_counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  // Widest thermometer the conversion helper accepts.
  localparam int THERM_MAX_W = 64;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    ACK      = 2'd2
  } chan_state_e;

  // A legal thermometer code is contiguous ones from bit 0, so its
  // population count is its binary value.
  function automatic logic [6:0] therm2bin(input logic [THERM_MAX_W-1:0] therm);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < THERM_MAX_W; i++) begin
      n = n + 7'(therm[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/hs_req_chan.sv
// One 4-phase request channel: synchroniser on the async req, a small FSM
// producing a registered ack and a single-cycle accept strobe.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// WAIT_LOW | waiting for a genuine low on req before arming
// IDLE     | armed; next synchronised high is accepted
// ACK      | accepted, ack high until synchronised req returns low
module hs_req_chan
  import hs_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic ack,
  output logic accept
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  chan_state_e            state_q, state_d;
  logic                   sync_req;
  logic                   sync_vld;

  // fill_q marks when the synchroniser holds real samples rather than reset
  // zeros, so a req held high across reset is never mistaken for a low.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req};
    fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
  end

  assign sync_req = sync_q[SYNC_STAGES-1];
  assign sync_vld = fill_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      WAIT_LOW: if (sync_vld && !sync_req) state_d = IDLE;
      IDLE: begin
        if (sync_req) begin
          state_d = ACK;
          accept  = 1'b1;
        end
      end
      ACK:      if (!sync_req) state_d = WAIT_LOW;
      default:  state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      state_q <= WAIT_LOW;
    end else begin
      sync_q  <= sync_d;
      fill_q  <= fill_d;
      state_q <= state_d;
    end
  end

  assign ack = (state_q == ACK);

endmodule

// File: rtl/hs_therm_counter.sv
// Up/down thermometer counter stepped by 4-phase inc/dec handshakes, with
// wrap or saturate behaviour at the bounds and registered status flags.
module hs_therm_counter
  import hs_counter_pkg::*;
#(
  parameter int DEPTH       = 10,
  parameter int MODE        = MODE_WRAP,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       incReq,
  output logic                       incAck,
  input  logic                       decReq,
  output logic                       decAck,
  input  logic                       clr,
  output logic [DEPTH-1:0]           therm,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       fin,
  output logic                       wrapPulse,
  output logic                       errPulse
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             inc_acc, dec_acc;
  logic [DEPTH-1:0] therm_q, therm_d;
  logic [CW-1:0]    count_q, count_d;
  logic             fin_q, fin_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  hs_req_chan #(.SYNC_STAGES(SYNC_STAGES)) u_inc_chan (
    .clk    (clk),
    .rst_n  (rstN),
    .req    (incReq),
    .ack    (incAck),
    .accept (inc_acc)
  );

  hs_req_chan #(.SYNC_STAGES(SYNC_STAGES)) u_dec_chan (
    .clk    (clk),
    .rst_n  (rstN),
    .req    (decReq),
    .ack    (decAck),
    .accept (dec_acc)
  );

  always_comb begin
    therm_d = therm_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (clr) begin
      therm_d = '0;
    end else if (inc_acc && dec_acc) begin
      therm_d = therm_q;
    end else if (inc_acc) begin
      if (therm_q[DEPTH-1]) begin
        if (MODE == MODE_WRAP) begin
          therm_d = '0;
          wrap_d  = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
      end else begin
        therm_d = {therm_q[DEPTH-2:0], 1'b1};
      end
    end else if (dec_acc) begin
      if (!therm_q[0]) begin
        if (MODE == MODE_WRAP) begin
          therm_d = '1;
          wrap_d  = 1'b1;
        end else begin
          err_d   = 1'b1;
        end
      end else begin
        therm_d = {1'b0, therm_q[DEPTH-1:1]};
      end
    end
    // count and fin come from the same next value so they never lag therm
    count_d = CW'(therm2bin(THERM_MAX_W'(therm_d)));
    fin_d   = therm_d[DEPTH-1];
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      therm_q <= '0;
      count_q <= '0;
      fin_q   <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      therm_q <= therm_d;
      count_q <= count_d;
      fin_q   <= fin_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign therm     = therm_q;
  assign count     = count_q;
  assign fin       = fin_q;
  assign wrapPulse = wrap_q;
  assign errPulse  = err_q;

  therm_legal_a: assert property (@(posedge clk) disable iff (!rstN)
    (therm_q & (therm_q + DEPTH'(1))) == '0);

endmodule
